jtdsp16_prom: RTL and testbench

- Parametrised successor to the DSP16 program ROM.
- Dual-read program memory: the PC port reads internal ROM only; the PT port reads internal ROM or external memory.
- External PT reads go through a request/acknowledge handshake with a wait-state timeout and a stall signal to the core.
- Byte-wide programming interface loads the internal array.

---
 rtl/jtdsp16_pkg.sv | 23 ++
 rtl/jtdsp16_prom_if.sv | 24 ++
 rtl/jtdsp16_prom_dp.sv | 33 +++
 rtl/jtdsp16_prom.sv | 189 ++++++++++++++++++
 tb/tb_jtdsp16_prom.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/jtdsp16_pkg.sv
// jtdsp16 program ROM shared types.
// PT FSM encoding, internal-region test, timeout fill.
package jtdsp16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IRD  = 2'd1,
    ST_EXT  = 2'd2,
    ST_DONE = 2'd3
  } pt_st_t;

  localparam logic [63:0] TOUT_FILL = '1;

  function automatic logic is_int(
    input logic [15:0] a,
    input int          aw
  );
    logic [15:0] m;
    m = 16'hffff << aw;
    return (a & m) == 16'd0;
  endfunction

endpackage

// File: rtl/jtdsp16_prom_if.sv
// External PT memory bus.
// The ROM is the master; the external memory answers with ext_ok.
interface jtdsp16_prom_if #(
  parameter int DW = 16
);
  logic          ext_rq;
  logic [15:0]   ext_addr;
  logic [DW-1:0] ext_data;
  logic          ext_ok;

  modport master (
    output ext_rq,
    output ext_addr,
    input  ext_data,
    input  ext_ok
  );

  modport slave (
    input  ext_rq,
    input  ext_addr,
    output ext_data,
    output ext_ok
  );
endinterface

// File: rtl/jtdsp16_prom_dp.sv
// Byte-wide dual-port RAM for the program ROM.
// Port A writes or reads; port B reads only.
module jtdsp16_prom_dp #(
  parameter int AW = 12,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] a_addr,
  input  logic [W-1:0]  a_din,
  input  logic          a_we,
  input  logic          a_en,
  output logic [W-1:0]  a_dout,
  input  logic [AW-1:0] b_addr,
  input  logic          b_en,
  output logic [W-1:0]  b_dout
);

  logic [W-1:0] mem [2**AW];

  // a_dout keeps its last read across write cycles
  always_ff @(posedge clk) begin
    if (a_we)
      mem[a_addr] <= a_din;
    else if (a_en)
      a_dout <= mem[a_addr];
  end

  always_ff @(posedge clk) begin
    if (b_en)
      b_dout <= mem[b_addr];
  end

endmodule

// File: rtl/jtdsp16_prom.sv
// DSP16 program ROM: PC port, PT port with external fallback.
// JTDSP16_PTCACHE_EN adds a one-entry cache of the last external read.
module jtdsp16_prom
  import jtdsp16_pkg::*;
#(
  parameter int AW   = 12,
  parameter int DW   = 16,
  parameter int TOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic [15:0]    addr,
  output logic [DW-1:0]  dout,
  input  logic [15:0]    pt,
  input  logic           pt_load,
  output logic [DW-1:0]  pt_dout,
  output logic           pt_ok,
  output logic           pt_busy,
  output logic           pt_err,
  jtdsp16_prom_if.master ext,
  input  logic [AW:0]    prog_addr,
  input  logic [DW/2-1:0] prog_data,
  input  logic           prog_we
);

  localparam int BW = DW / 2;
  localparam logic [7:0] TLIM = 8'(TOUT - 1);

  pt_st_t        st, st_n;
  logic [AW-1:0] pt_q;
  logic [AW-1:0] a_addr;
  logic [7:0]    cnt;
  logic          rd_ok;
  logic          pc_int;
  logic [DW-1:0] pt_dq;
  logic [BW-1:0] a_hi, a_lo, b_hi, b_lo;
  logic          ld, ld_int, ld_hit, ird_go;
  logic          hit;
  logic [DW-1:0] c_dat;

  assign a_addr = prog_we         ? prog_addr[AW:1] :
                  (st == ST_IDLE) ? pt[AW-1:0]      :
                                    pt_q;

  jtdsp16_prom_dp #(.AW(AW), .W(BW)) u_hi (
    .clk    (clk),
    .a_addr (a_addr),
    .a_din  (prog_data),
    .a_we   (prog_we & prog_addr[0]),
    .a_en   (~prog_we),
    .a_dout (a_hi),
    .b_addr (addr[AW-1:0]),
    .b_en   (cen),
    .b_dout (b_hi)
  );

  jtdsp16_prom_dp #(.AW(AW), .W(BW)) u_lo (
    .clk    (clk),
    .a_addr (a_addr),
    .a_din  (prog_data),
    .a_we   (prog_we & ~prog_addr[0]),
    .a_en   (~prog_we),
    .a_dout (a_lo),
    .b_addr (addr[AW-1:0]),
    .b_en   (cen),
    .b_dout (b_lo)
  );

  assign dout    = pc_int ? {b_hi, b_lo} : '0;
  assign pt_dout = (st == ST_IRD) ? {a_hi, a_lo} : pt_dq;

`ifdef JTDSP16_PTCACHE_EN
  logic        c_vld;
  logic [15:0] c_tag;

  assign hit = c_vld && (c_tag == pt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld <= 1'b0;
      c_tag <= '0;
      c_dat <= '0;
    end else if (prog_we) begin
      c_vld <= 1'b0;
    end else if (st == ST_EXT && ext.ext_ok) begin
      c_vld <= 1'b1;
      c_tag <= ext.ext_addr;
      c_dat <= ext.ext_data;
    end
  end
`else
  assign hit   = 1'b0;
  assign c_dat = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      st <= ST_IDLE;
    else
      st <= st_n;
  end

  always_comb begin
    st_n    = st;
    pt_ok   = 1'b0;
    pt_busy = 1'b0;
    ld      = 1'b0;
    ld_int  = 1'b0;
    ld_hit  = 1'b0;
    ird_go  = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (cen && pt_load) begin
          ld      = 1'b1;
          pt_busy = 1'b1;
          if (is_int(pt, AW)) begin
            ld_int = 1'b1;
            st_n   = ST_IRD;
          end else if (hit) begin
            ld_hit = 1'b1;
            st_n   = ST_DONE;
          end else begin
            st_n = ST_EXT;
          end
        end
      end
      ST_IRD: begin
        pt_busy = 1'b1;
        // a write on port A this cycle holds the read back
        if (!prog_we && rd_ok) begin
          ird_go = 1'b1;
          pt_ok  = 1'b1;
          st_n   = ST_IDLE;
        end
      end
      ST_EXT: begin
        pt_busy = 1'b1;
        if (ext.ext_ok || cnt == TLIM)
          st_n = ST_DONE;
      end
      ST_DONE: begin
        pt_ok = 1'b1;
        st_n  = ST_IDLE;
      end
      default: st_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_q         <= '0;
      cnt          <= '0;
      rd_ok        <= 1'b0;
      pc_int       <= 1'b0;
      pt_dq        <= '0;
      pt_err       <= 1'b0;
      ext.ext_rq   <= 1'b0;
      ext.ext_addr <= '0;
    end else begin
      rd_ok <= !prog_we || (st == ST_IRD && rd_ok);
      cnt   <= (st == ST_EXT) ? cnt + 8'd1 : 8'd0;
      if (cen)
        pc_int <= is_int(addr, AW);
      if (ld)
        pt_q <= pt[AW-1:0];
      if (ld && !ld_int && !ld_hit) begin
        ext.ext_rq   <= 1'b1;
        ext.ext_addr <= pt;
      end
      if (ird_go)
        pt_dq <= {a_hi, a_lo};
      if (ld_hit)
        pt_dq <= c_dat;
      // data beats the timeout when both land together
      if (st == ST_EXT) begin
        if (ext.ext_ok) begin
          pt_dq      <= ext.ext_data;
          ext.ext_rq <= 1'b0;
        end else if (cnt == TLIM) begin
          pt_dq      <= TOUT_FILL[DW-1:0];
          pt_err     <= 1'b1;
          ext.ext_rq <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtdsp16_prom.sv
// Directed bench for jtdsp16_prom.
// Covers PC reads, PT internal/external/timeout, collision, reset.
module tb_jtdsp16_prom;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b0;
  logic [15:0]   addr = '0;
  logic [DW-1:0] dout;
  logic [15:0]   pt = '0;
  logic          pt_load = 1'b0;
  logic [DW-1:0] pt_dout;
  logic          pt_ok;
  logic          pt_busy;
  logic          pt_err;
  logic [AW:0]   prog_addr = '0;
  logic [7:0]    prog_data = '0;
  logic          prog_we = 1'b0;

  int checks = 0;
  int errors = 0;

  jtdsp16_prom_if #(.DW(DW)) ext ();

  jtdsp16_prom #(.AW(AW), .DW(DW), .TOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .addr      (addr),
    .dout      (dout),
    .pt        (pt),
    .pt_load   (pt_load),
    .pt_dout   (pt_dout),
    .pt_ok     (pt_ok),
    .pt_busy   (pt_busy),
    .pt_err    (pt_err),
    .ext       (ext.master),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_we   (prog_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [AW:0] a, input logic [7:0] d);
    prog_addr = a;
    prog_data = d;
    prog_we   = 1'b1;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic load(input logic [15:0] a);
    pt      = a;
    pt_load = 1'b1;
    #1;
    chk("busy_comb", 32'(pt_busy), 32'd1);
    tick();
    pt_load = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int n;
    ext.ext_ok   = 1'b0;
    ext.ext_data = '0;
    #1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_pt_dout", 32'(pt_dout), 32'h0);
    chk("rst_pt_ok", 32'(pt_ok), 32'd0);
    chk("rst_busy", 32'(pt_busy), 32'd0);
    chk("rst_err", 32'(pt_err), 32'd0);
    chk("rst_rq", 32'(ext.ext_rq), 32'd0);
    chk("rst_eaddr", 32'(ext.ext_addr), 32'h0);

    // programming works while in reset
    prog(13'h00A, 8'hEF);
    prog(13'h00B, 8'hBE);
    prog(13'h1FFE, 8'h5A);
    prog(13'h1FFF, 8'hA5);
    rst_n = 1'b1;

    cen = 1'b1; addr = 16'h0005; tick();
    chk("pc_5", 32'(dout), 32'hBEEF);
    addr = 16'h1005; tick();
    chk("pc_outside", 32'(dout), 32'h0);
    addr = 16'h0FFF; tick();
    chk("pc_top", 32'(dout), 32'hA55A);
    cen = 1'b0; addr = 16'h0005; tick();
    chk("pc_hold", 32'(dout), 32'hA55A);
    cen = 1'b1;

    load(16'h0005);
    chk("int_ok", 32'(pt_ok), 32'd1);
    chk("int_data", 32'(pt_dout), 32'hBEEF);
    chk("int_rq", 32'(ext.ext_rq), 32'd0);
    tick();
    chk("int_ok_drop", 32'(pt_ok), 32'd0);
    chk("int_busy_drop", 32'(pt_busy), 32'd0);
    chk("int_data_hold", 32'(pt_dout), 32'hBEEF);

    // ext_ok on the very cycle the counter expires
    load(16'h4000);
    chk("edge_rq", 32'(ext.ext_rq), 32'd1);
    repeat (14) tick();
    chk("edge_rq_late", 32'(ext.ext_rq), 32'd1);
    ext.ext_ok = 1'b1; ext.ext_data = 16'h5A5A;
    tick();
    ext.ext_ok = 1'b0;
    chk("edge_ok", 32'(pt_ok), 32'd1);
    chk("edge_data", 32'(pt_dout), 32'h5A5A);
    chk("edge_err", 32'(pt_err), 32'd0);
    chk("edge_rq_drop", 32'(ext.ext_rq), 32'd0);
    tick();

    load(16'h2345);
    chk("ext_rq", 32'(ext.ext_rq), 32'd1);
    chk("ext_ok_early", 32'(pt_ok), 32'd0);
    pt = 16'h0005; pt_load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ext_addr", 32'(ext.ext_addr), 32'h2345);
      tick();
    end
    pt_load = 1'b0;
    ext.ext_ok = 1'b1; ext.ext_data = 16'h1234;
    tick();
    ext.ext_ok = 1'b0;
    chk("ext_done_ok", 32'(pt_ok), 32'd1);
    chk("ext_data", 32'(pt_dout), 32'h1234);
    chk("ext_rq_drop", 32'(ext.ext_rq), 32'd0);
    chk("ext_err", 32'(pt_err), 32'd0);
    tick();
    chk("ext_ok_drop", 32'(pt_ok), 32'd0);
    chk("ext_busy_drop", 32'(pt_busy), 32'd0);

`ifdef JTDSP16_PTCACHE_EN
    load(16'h2345);
    chk("hit_rq", 32'(ext.ext_rq), 32'd0);
    chk("hit_ok", 32'(pt_ok), 32'd1);
    chk("hit_data", 32'(pt_dout), 32'h1234);
    tick();
    prog(13'h00C, 8'h11);
`endif
    load(16'h2345);
    chk("re_rq", 32'(ext.ext_rq), 32'd1);
    ext.ext_ok = 1'b1; ext.ext_data = 16'h4321;
    tick();
    ext.ext_ok = 1'b0;
    chk("re_data", 32'(pt_dout), 32'h4321);
    tick();

    load(16'h8000);
    n = 0;
    while (ext.ext_rq && n < 100) begin
      n++;
      tick();
    end
    chk("tout_cycles", 32'(n), 32'd15);
    chk("tout_ok", 32'(pt_ok), 32'd1);
    chk("tout_data", 32'(pt_dout), 32'hFFFF);
    chk("tout_err", 32'(pt_err), 32'd1);
    tick();

    load(16'h0005);
    chk("after_data", 32'(pt_dout), 32'hBEEF);
    chk("err_sticky", 32'(pt_err), 32'd1);
    tick();

    // programming write lands while IRD is waiting
    load(16'h0005);
    prog_addr = 13'h00C; prog_data = 8'h77; prog_we = 1'b1;
    #1;
    chk("col_ok", 32'(pt_ok), 32'd0);
    chk("col_busy", 32'(pt_busy), 32'd1);
    tick();
    prog_we = 1'b0;
    #1;
    chk("col_ok_late", 32'(pt_ok), 32'd1);
    chk("col_data", 32'(pt_dout), 32'hBEEF);
    tick();
    chk("col_ok_drop", 32'(pt_ok), 32'd0);

    load(16'h3000);
    chk("mid_rq", 32'(ext.ext_rq), 32'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rq_drop", 32'(ext.ext_rq), 32'd0);
    chk("mid_ok", 32'(pt_ok), 32'd0);
    chk("mid_busy", 32'(pt_busy), 32'd0);
    chk("mid_err_clr", 32'(pt_err), 32'd0);
    chk("mid_dout", 32'(dout), 32'h0);
    tick();
    tick();
    chk("mid_ok_hold", 32'(pt_ok), 32'd0);
    rst_n = 1'b1;
    tick();

    load(16'h2345);
    chk("post_rq", 32'(ext.ext_rq), 32'd1);
    chk("post_addr", 32'(ext.ext_addr), 32'h2345);
    ext.ext_ok = 1'b1; ext.ext_data = 16'hCAFE;
    tick();
    ext.ext_ok = 1'b0;
    chk("post_ok", 32'(pt_ok), 32'd1);
    chk("post_data", 32'(pt_dout), 32'hCAFE);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
